// File: rtl/lab5_fetch_unit.sv
// Instruction fetch stage: a PC register, an IR latch, and a RUN/HALT machine.
// Optional issue counter on FETCH_CNT is built when LAB5_FETCH_PERF_EN is defined.
module lab5_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [7:0]  BR_TARGET,
    input  logic [15:0] IMEM_Q,
    output logic [7:0]  IMEM_ADDR,
    output logic [15:0] IR,
    output logic [7:0]  IR_PC,
    output logic        IR_VALID,
    output logic        HALTED,
    output logic [15:0] FETCH_CNT
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [7:0]  PC_ALIGN  = 8'hFE;
    localparam logic [7:0]  PC_STEP   = 8'd2;
    localparam logic [15:0] HALT_WORD = 16'h0000;

    state_t      state_q,    state_d;
    logic [7:0]  pc_q,       pc_d;
    logic [15:0] ir_q,       ir_d;
    logic [7:0]  ir_pc_q,    ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        halted_q,   halted_d;
    logic        issue_d;

    // Branch wins over everything except reset; HALT only listens for a branch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        issue_d    = 1'b0;
        if (BR_TAKEN) begin
            pc_d       = BR_TARGET & PC_ALIGN;
            ir_valid_d = 1'b0;
            halted_d   = 1'b0;
            state_d    = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!STALL) begin
                        if (IMEM_Q == HALT_WORD) begin
                            ir_valid_d = 1'b0;
                            halted_d   = 1'b1;
                            state_d    = ST_HALT;
                        end else begin
                            ir_d       = IMEM_Q;
                            ir_pc_d    = pc_q;
                            ir_valid_d = 1'b1;
                            pc_d       = pc_q + PC_STEP;
                            issue_d    = 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    ir_valid_d = 1'b0;
                    halted_d   = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC & PC_ALIGN;
            ir_q       <= 16'h0000;
            ir_pc_q    <= 8'h00;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

`ifdef LAB5_FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (issue_d && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_cnt_q <= 16'h0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign FETCH_CNT = fetch_cnt_q;
`else
    logic unused_issue;
    assign unused_issue = issue_d;
    assign FETCH_CNT    = 16'h0000;
`endif

    assign IMEM_ADDR = pc_q;
    assign IR        = ir_q;
    assign IR_PC     = ir_pc_q;
    assign IR_VALID  = ir_valid_q;
    assign HALTED    = halted_q;

endmodule

// File: tb/tb_lab5_fetch_unit.sv
// Randomised bench for lab5_fetch_unit: a behavioural fetch model plus directed pins.
module tb_lab5_fetch_unit;

    localparam logic [7:0] RST_PC = 8'h11;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic [7:0]  BR_TARGET = 8'h00;
    logic [15:0] IMEM_Q;
    logic [7:0]  IMEM_ADDR;
    logic [15:0] IR;
    logic [7:0]  IR_PC;
    logic        IR_VALID;
    logic        HALTED;
    logic [15:0] FETCH_CNT;

    logic [15:0] mem [0:127];

    always #5 CLK = ~CLK;

    assign IMEM_Q = mem[IMEM_ADDR[7:1]];

    lab5_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
        .BR_TARGET(BR_TARGET), .IMEM_Q(IMEM_Q), .IMEM_ADDR(IMEM_ADDR),
        .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID), .HALTED(HALTED),
        .FETCH_CNT(FETCH_CNT)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain variables, one rule per clock edge.
    int unsigned m_pc, m_ir, m_irpc, m_cnt;
    bit m_valid, m_halted, m_live;

    always @(posedge CLK) begin
        int unsigned word;
        word = mem[m_pc / 2];
        if (RESET) begin
            m_pc = RST_PC - (RST_PC % 2);
            m_ir = 0; m_irpc = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
            m_live = 1;
        end else if (BR_TAKEN) begin
            m_pc = BR_TARGET - (BR_TARGET % 2);
            m_valid = 0; m_halted = 0;
        end else if (m_halted || STALL) begin
        end else if (word == 0) begin
            m_valid = 0; m_halted = 1;
        end else begin
            m_ir = word; m_irpc = m_pc; m_valid = 1;
            m_pc = (m_pc + 2) % 256;
`ifdef LAB5_FETCH_PERF_EN
            if (m_cnt < 65535) m_cnt++;
`endif
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            chk("imem_addr", 32'(IMEM_ADDR), m_pc);
            chk("ir",        32'(IR),        m_ir);
            chk("ir_pc",     32'(IR_PC),     m_irpc);
            chk("ir_valid",  32'(IR_VALID),  32'(m_valid));
            chk("halted",    32'(HALTED),    32'(m_halted));
            chk("fetch_cnt", 32'(FETCH_CNT), m_cnt);
        end
    end

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input bit rst, input bit stl, input bit br, input logic [7:0] tgt);
        RESET = rst; STALL = stl; BR_TAKEN = br; BR_TARGET = tgt;
    endtask

    initial begin
        logic [15:0] cnt_before;
        for (int i = 0; i < 128; i++) mem[i] = 16'(($urandom | 1) & 16'hFFFF);
        m_live = 0;

        drive(1, 0, 0, 8'h00);
        tick; tick;
        chk("rst_addr",   32'(IMEM_ADDR), 32'h10);
        chk("rst_valid",  32'(IR_VALID),  0);
        chk("rst_ir",     32'(IR),        0);
        chk("rst_halted", 32'(HALTED),    0);
        chk("rst_cnt",    32'(FETCH_CNT), 0);

        drive(0, 0, 1, 8'h00);
        tick;
        chk("br0_addr", 32'(IMEM_ADDR), 32'h00);
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("seq_irpc",  32'(IR_PC), 32'(2 * i));
            chk("seq_addr",  32'(IMEM_ADDR), 32'(2 * i + 2));
            chk("seq_valid", 32'(IR_VALID), 1);
        end

        // Back up to PC=06 and hold it there.
        drive(0, 0, 1, 8'h04);
        tick;
        drive(0, 0, 0, 8'h00);
        tick;
        cnt_before = FETCH_CNT;
        drive(0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall_addr", 32'(IMEM_ADDR), 32'h06);
            chk("stall_irpc", 32'(IR_PC), 32'h04);
            chk("stall_ir",   32'(IR), 32'(mem[2]));
            chk("stall_cnt",  32'(FETCH_CNT), 32'(cnt_before));
        end

        drive(0, 1, 1, 8'h21);
        tick;
        chk("br21_addr",  32'(IMEM_ADDR), 32'h20);
        chk("br21_valid", 32'(IR_VALID), 0);
        drive(0, 0, 0, 8'h00);
        tick;
        chk("br21_irpc",  32'(IR_PC), 32'h20);

        drive(0, 0, 1, 8'hFE);
        tick;
        drive(0, 0, 0, 8'h00);
        tick;
        chk("wrap_irpc", 32'(IR_PC), 32'hFE);
        chk("wrap_addr", 32'(IMEM_ADDR), 32'h00);

        mem[8'h36 / 2] = 16'h0000;
        drive(0, 0, 1, 8'h36);
        tick;
        drive(0, 0, 0, 8'h00);
        tick;
        chk("halt_flag",  32'(HALTED), 1);
        chk("halt_valid", 32'(IR_VALID), 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 0, 8'h00);
            tick;
            chk("halt_addr", 32'(IMEM_ADDR), 32'h36);
        end
        drive(0, 0, 1, 8'h00);
        tick;
        chk("unhalt_flag", 32'(HALTED), 0);
        chk("unhalt_addr", 32'(IMEM_ADDR), 32'h00);

        drive(0, 0, 1, 8'h36);
        tick;
        drive(0, 0, 0, 8'h00);
        tick;
        chk("rehalt_flag", 32'(HALTED), 1);
        drive(1, 1, 1, 8'h80);
        tick;
        chk("rsth_halted", 32'(HALTED), 0);
        chk("rsth_addr",   32'(IMEM_ADDR), 32'h10);
        chk("rsth_cnt",    32'(FETCH_CNT), 0);

        // Random phase: sparse halt words, random stalls, branches and resets.
        for (int i = 0; i < 128; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'(($urandom | 1) & 16'hFFFF);
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) < 2),
                  1'($urandom_range(0, 99) < 25),
                  1'($urandom_range(0, 99) < 10),
                  8'($urandom_range(0, 255)));
            if (i % 500 == 0) mem[$urandom_range(0, 127)] = 16'(($urandom | 1) & 16'hFFFF);
            tick;
        end

        drive(0, 0, 0, 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
